// File: rtl/rs_v_issue.sv
// rs_v_issue -- vector reservation-station issue unit.
//
// Holds decoded vector load/store/add-sub entries, tracks per-chunk source
// readiness from writeback broadcasts and issues each held instruction to the
// vector execute pipe as four 8-element chunks, freeing the entry after the
// last chunk.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   alloc_*                 decode-side entry write (valid/ready handshake)
//   wb_v_*                  vector chunk writeback broadcast (reg + chunk)
//   wb_s_*                  scalar writeback broadcast (reg)
//   disp_*                  chunk issue to execute (valid/ready handshake)
//   rs_full, free_count     occupancy status from registered valid bits
//
// Optional build macro:
//   RS_V_AGE_PRIO_EN        oldest-first selection using a per-entry age rank;
//                           when undefined, the lowest ready index issues.

module rs_v_issue #(
    parameter int RS_SIZE = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [6:0]       alloc_opcode,
    input  logic [8:0]       alloc_func,
    input  logic [4:0]       alloc_dest,
    input  logic [4:0]       alloc_src1,
    input  logic [4:0]       alloc_src2,
    input  logic             alloc_src1_scalar,
    input  logic [3:0]       alloc_src1_busy,
    input  logic [3:0]       alloc_src2_busy,

    input  logic             wb_v_valid,
    input  logic [4:0]       wb_v_reg,
    input  logic [1:0]       wb_v_chunk,
    input  logic             wb_s_valid,
    input  logic [4:0]       wb_s_reg,

    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [6:0]       disp_opcode,
    output logic [8:0]       disp_func,
    output logic [4:0]       disp_dest,
    output logic [4:0]       disp_src1,
    output logic [4:0]       disp_src2,
    output logic [1:0]       disp_chunk,
    output logic             disp_last,
    output logic [IDX_W-1:0] disp_idx,

    output logic             rs_full,
    output logic [IDX_W:0]   free_count
);

    localparam logic [6:0] OP_STORE = 7'b0100111;

    logic [RS_SIZE-1:0] ent_valid;
    logic [6:0]         ent_opcode     [RS_SIZE];
    logic [8:0]         ent_func       [RS_SIZE];
    logic [4:0]         ent_dest       [RS_SIZE];
    logic [4:0]         ent_src1       [RS_SIZE];
    logic [4:0]         ent_src2       [RS_SIZE];
    logic [RS_SIZE-1:0] ent_src1_scalar;
    logic [3:0]         ent_src1_busy  [RS_SIZE];
    logic [3:0]         ent_src2_busy  [RS_SIZE];
    logic [1:0]         ent_next_chunk [RS_SIZE];
`ifdef RS_V_AGE_PRIO_EN
    logic [IDX_W-1:0]   ent_rank       [RS_SIZE];
    logic [IDX_W-1:0]   sel_rank;
    logic [IDX_W-1:0]   alloc_rank;
`endif

    logic [3:0]         wb_v_mask;
    logic [3:0]         src1_busy_wk   [RS_SIZE];
    logic [3:0]         src2_busy_wk   [RS_SIZE];
    logic [3:0]         alloc_src1_busy_wk;
    logic [3:0]         alloc_src2_busy_wk;

    logic [RS_SIZE-1:0] ent_ready;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W:0]     valid_count;
    logic               alloc_fire;
    logic               disp_fire;
    logic               free_fire;

    // Vector broadcasts only wake vector sources; a scalar broadcast makes a
    // scalar source ready for every chunk at once.
    function automatic logic [3:0] wake_src1(
        input logic [3:0] busy,
        input logic [4:0] src,
        input logic       scalar,
        input logic       v_valid,
        input logic [4:0] v_reg,
        input logic [3:0] v_mask,
        input logic       s_valid,
        input logic [4:0] s_reg
    );
        logic [3:0] res;
        res = busy;
        if (v_valid && !scalar && (src == v_reg)) begin
            res = res & ~v_mask;
        end
        if (s_valid && scalar && (src == s_reg)) begin
            res = 4'b0000;
        end
        return res;
    endfunction

    function automatic logic [3:0] wake_src2(
        input logic [3:0] busy,
        input logic [4:0] src,
        input logic       v_valid,
        input logic [4:0] v_reg,
        input logic [3:0] v_mask
    );
        logic [3:0] res;
        res = busy;
        if (v_valid && (src == v_reg)) begin
            res = res & ~v_mask;
        end
        return res;
    endfunction

    assign wb_v_mask = 4'b0001 << wb_v_chunk;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            src1_busy_wk[i] = wake_src1(ent_src1_busy[i], ent_src1[i], ent_src1_scalar[i],
                                        wb_v_valid, wb_v_reg, wb_v_mask, wb_s_valid, wb_s_reg);
            src2_busy_wk[i] = wake_src2(ent_src2_busy[i], ent_src2[i],
                                        wb_v_valid, wb_v_reg, wb_v_mask);
        end
        // Same-cycle broadcasts are folded into the masks being captured.
        alloc_src1_busy_wk = wake_src1(alloc_src1_busy, alloc_src1, alloc_src1_scalar,
                                       wb_v_valid, wb_v_reg, wb_v_mask, wb_s_valid, wb_s_reg);
        alloc_src2_busy_wk = wake_src2(alloc_src2_busy, alloc_src2,
                                       wb_v_valid, wb_v_reg, wb_v_mask);
    end

    // Stores need the whole scalar base ready before any chunk goes; other
    // ops only need the chunk about to issue.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            logic src1_ok;
            if (ent_opcode[i] == OP_STORE) begin
                src1_ok = (ent_src1_busy[i] == 4'b0000);
            end else begin
                src1_ok = !ent_src1_busy[i][ent_next_chunk[i]];
            end
            ent_ready[i] = ent_valid[i] && src1_ok && !ent_src2_busy[i][ent_next_chunk[i]];
        end
    end

`ifdef RS_V_AGE_PRIO_EN
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_ready[i] && (!sel_found || (ent_rank[i] < sel_rank))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = ent_rank[i];
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ent_ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_count = valid_count + {{IDX_W{1'b0}}, ent_valid[i]};
        end
    end

    assign rs_full     = &ent_valid;
    assign alloc_ready = !rs_full;
    assign free_count  = (IDX_W + 1)'(RS_SIZE) - valid_count;

    always_comb begin
        disp_opcode = '0;
        disp_func   = '0;
        disp_dest   = '0;
        disp_src1   = '0;
        disp_src2   = '0;
        disp_chunk  = '0;
        disp_idx    = '0;
        if (sel_found) begin
            disp_opcode = ent_opcode[sel_idx];
            disp_func   = ent_func[sel_idx];
            disp_dest   = ent_dest[sel_idx];
            disp_src1   = ent_src1[sel_idx];
            disp_src2   = ent_src2[sel_idx];
            disp_chunk  = ent_next_chunk[sel_idx];
            disp_idx    = sel_idx;
        end
    end

    assign disp_valid = sel_found;
    assign disp_last  = sel_found && (disp_chunk == 2'd3);
    assign alloc_fire = alloc_valid && alloc_ready;
    assign disp_fire  = disp_valid && disp_ready;
    assign free_fire  = disp_fire && disp_last;

`ifdef RS_V_AGE_PRIO_EN
    // Ranks stay dense: the entry freed this cycle always ranks below the
    // current count, so a simultaneous allocation lands one lower.
    assign alloc_rank = IDX_W'(valid_count) - IDX_W'(free_fire);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid       <= '0;
            ent_src1_scalar <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_opcode[i]     <= '0;
                ent_func[i]       <= '0;
                ent_dest[i]       <= '0;
                ent_src1[i]       <= '0;
                ent_src2[i]       <= '0;
                ent_src1_busy[i]  <= '0;
                ent_src2_busy[i]  <= '0;
                ent_next_chunk[i] <= '0;
`ifdef RS_V_AGE_PRIO_EN
                ent_rank[i]       <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_src1_busy[i] <= src1_busy_wk[i];
                ent_src2_busy[i] <= src2_busy_wk[i];
                if (disp_fire && (sel_idx == IDX_W'(i))) begin
                    if (ent_next_chunk[i] == 2'd3) begin
                        ent_valid[i]      <= 1'b0;
                        ent_next_chunk[i] <= 2'd0;
                    end else begin
                        ent_next_chunk[i] <= ent_next_chunk[i] + 2'd1;
                    end
                end
`ifdef RS_V_AGE_PRIO_EN
                if (free_fire && ent_valid[i] && (ent_rank[i] > sel_rank)) begin
                    ent_rank[i] <= ent_rank[i] - 1'b1;
                end
`endif
            end

            // The allocated slot was invalid, so it never collides with the
            // dispatching entry; these writes simply override the loop above.
            if (alloc_fire) begin
                ent_valid[alloc_idx]       <= 1'b1;
                ent_opcode[alloc_idx]      <= alloc_opcode;
                ent_func[alloc_idx]        <= alloc_func;
                ent_dest[alloc_idx]        <= alloc_dest;
                ent_src1[alloc_idx]        <= alloc_src1;
                ent_src2[alloc_idx]        <= alloc_src2;
                ent_src1_scalar[alloc_idx] <= alloc_src1_scalar;
                ent_src1_busy[alloc_idx]   <= alloc_src1_busy_wk;
                ent_src2_busy[alloc_idx]   <= alloc_src2_busy_wk;
                ent_next_chunk[alloc_idx]  <= 2'd0;
`ifdef RS_V_AGE_PRIO_EN
                ent_rank[alloc_idx]        <= alloc_rank;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rs_v_issue.sv
// Directed bench for rs_v_issue: reset state, full-instruction issue,
// scalar/vector wakeup, store readiness, full-RS handling, same-cycle
// wakeup bypass and selection priority (age or index, by build macro).

module tb_rs_v_issue;

    localparam logic [6:0] OP_VADD  = 7'b1010111;
    localparam logic [6:0] OP_STORE = 7'b0100111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [6:0] alloc_opcode;
    logic [8:0] alloc_func;
    logic [4:0] alloc_dest;
    logic [4:0] alloc_src1;
    logic [4:0] alloc_src2;
    logic       alloc_src1_scalar;
    logic [3:0] alloc_src1_busy;
    logic [3:0] alloc_src2_busy;
    logic       wb_v_valid;
    logic [4:0] wb_v_reg;
    logic [1:0] wb_v_chunk;
    logic       wb_s_valid;
    logic [4:0] wb_s_reg;
    logic       disp_valid;
    logic       disp_ready;
    logic [6:0] disp_opcode;
    logic [8:0] disp_func;
    logic [4:0] disp_dest;
    logic [4:0] disp_src1;
    logic [4:0] disp_src2;
    logic [1:0] disp_chunk;
    logic       disp_last;
    logic [1:0] disp_idx;
    logic       rs_full;
    logic [2:0] free_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_v_issue #(.RS_SIZE(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_opcode(alloc_opcode), .alloc_func(alloc_func), .alloc_dest(alloc_dest),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .alloc_src1_scalar(alloc_src1_scalar),
        .alloc_src1_busy(alloc_src1_busy), .alloc_src2_busy(alloc_src2_busy),
        .wb_v_valid(wb_v_valid), .wb_v_reg(wb_v_reg), .wb_v_chunk(wb_v_chunk),
        .wb_s_valid(wb_s_valid), .wb_s_reg(wb_s_reg),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_func(disp_func), .disp_dest(disp_dest),
        .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_chunk(disp_chunk),
        .disp_last(disp_last), .disp_idx(disp_idx),
        .rs_full(rs_full), .free_count(free_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid       = 1'b0;
        alloc_opcode      = '0;
        alloc_func        = '0;
        alloc_dest        = '0;
        alloc_src1        = '0;
        alloc_src2        = '0;
        alloc_src1_scalar = 1'b0;
        alloc_src1_busy   = '0;
        alloc_src2_busy   = '0;
        wb_v_valid        = 1'b0;
        wb_v_reg          = '0;
        wb_v_chunk        = '0;
        wb_s_valid        = 1'b0;
        wb_s_reg          = '0;
        disp_ready        = 1'b0;
    endtask

    task automatic set_alloc(input logic [6:0] op, input logic [8:0] fn, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic sc,
                             input logic [3:0] b1, input logic [3:0] b2);
        alloc_valid       = 1'b1;
        alloc_opcode      = op;
        alloc_func        = fn;
        alloc_dest        = d;
        alloc_src1        = s1;
        alloc_src2        = s2;
        alloc_src1_scalar = sc;
        alloc_src1_busy   = b1;
        alloc_src2_busy   = b2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_dest;
        int second_dest;

        rst_n = 1'b0;
        idle_inputs();
        step();
        step();

        // Reset state
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_disp_dest", 32'(disp_dest), 32'd0);
        check("rst_disp_chunk", 32'(disp_chunk), 32'd0);
        check("rst_rs_full", 32'(rs_full), 32'd0);
        check("rst_free_count", 32'(free_count), 32'd4);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);

        // vadd, all sources ready: four back-to-back chunks
        rst_n = 1'b1;
        disp_ready = 1'b1;
        set_alloc(OP_VADD, 9'h000, 5'd3, 5'd1, 5'd2, 1'b0, 4'b0000, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("vadd_free_after_alloc", 32'(free_count), 32'd3);
        check("vadd_opcode", 32'(disp_opcode), 32'(OP_VADD));
        check("vadd_dest", 32'(disp_dest), 32'd3);
        check("vadd_src2", 32'(disp_src2), 32'd2);
        check("vadd_idx", 32'(disp_idx), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("vadd_valid", 32'(disp_valid), 32'd1);
            check("vadd_chunk", 32'(disp_chunk), 32'(c));
            check("vadd_last", 32'(disp_last), (c == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("vadd_done_valid", 32'(disp_valid), 32'd0);
        check("vadd_done_free", 32'(free_count), 32'd4);

        // vsub with scalar src1 busy: vector broadcast must not wake it
        set_alloc(OP_VADD, 9'b000010100, 5'd4, 5'd7, 5'd2, 1'b1, 4'b1111, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("vsub_blocked", 32'(disp_valid), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd7; wb_v_chunk = 2'd0;
        step();
        wb_v_valid = 1'b0;
        check("vsub_wbv_no_wake", 32'(disp_valid), 32'd0);
        wb_s_valid = 1'b1; wb_s_reg = 5'd8;
        step();
        check("vsub_wbs_wrong_reg", 32'(disp_valid), 32'd0);
        wb_s_reg = 5'd7;
        step();
        wb_s_valid = 1'b0;
        check("vsub_func", 32'(disp_func), 32'h014);
        for (int c = 0; c < 4; c++) begin
            check("vsub_valid", 32'(disp_valid), 32'd1);
            check("vsub_chunk", 32'(disp_chunk), 32'(c));
            step();
        end
        check("vsub_done_free", 32'(free_count), 32'd4);

        // store, src2 busy 1110: chunks gated one by one by vector wakeups
        set_alloc(OP_STORE, 9'h006, 5'd6, 5'd5, 5'd9, 1'b1, 4'b0000, 4'b1110);
        step();
        alloc_valid = 1'b0;
        check("st_c0_valid", 32'(disp_valid), 32'd1);
        check("st_c0_chunk", 32'(disp_chunk), 32'd0);
        step();
        check("st_c1_blocked_a", 32'(disp_valid), 32'd0);
        step();
        check("st_c1_blocked_b", 32'(disp_valid), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd9; wb_v_chunk = 2'd1;
        step();
        wb_v_valid = 1'b0;
        check("st_c1_valid", 32'(disp_valid), 32'd1);
        check("st_c1_chunk", 32'(disp_chunk), 32'd1);
        step();
        check("st_c2_blocked", 32'(disp_valid), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd10; wb_v_chunk = 2'd2;
        step();
        check("st_c2_wrong_reg", 32'(disp_valid), 32'd0);
        wb_v_reg = 5'd9;
        step();
        wb_v_valid = 1'b0;
        check("st_c2_chunk", 32'(disp_chunk), 32'd2);
        check("st_c2_last", 32'(disp_last), 32'd0);
        step();
        check("st_c3_blocked_a", 32'(disp_valid), 32'd0);
        step();
        check("st_c3_blocked_b", 32'(disp_valid), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd9; wb_v_chunk = 2'd3;
        step();
        wb_v_valid = 1'b0;
        check("st_c3_chunk", 32'(disp_chunk), 32'd3);
        check("st_c3_last", 32'(disp_last), 32'd1);
        step();
        check("st_done_valid", 32'(disp_valid), 32'd0);
        check("st_done_free", 32'(free_count), 32'd4);

        // store src1 checked as a whole: a busy chunk-3 bit blocks chunk 0
        set_alloc(OP_STORE, 9'h006, 5'd6, 5'd11, 5'd12, 1'b1, 4'b1000, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("st_src1_whole", 32'(disp_valid), 32'd0);
        wb_s_valid = 1'b1; wb_s_reg = 5'd11;
        step();
        wb_s_valid = 1'b0;
        check("st_src1_woken", 32'(disp_valid), 32'd1);
        for (int c = 0; c < 4; c++) step();
        check("st2_done_free", 32'(free_count), 32'd4);

        // Fill all four entries; only idx 3 is ready
        disp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_alloc(OP_VADD, 9'h000, 5'(16 + k), 5'd20, 5'd21, 1'b0, 4'b1111, 4'b0000);
            step();
        end
        set_alloc(OP_VADD, 9'h000, 5'd19, 5'd22, 5'd23, 1'b0, 4'b0000, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("full_rs_full", 32'(rs_full), 32'd1);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_free", 32'(free_count), 32'd0);
        check("full_disp_idx", 32'(disp_idx), 32'd3);
        step();
        check("full_stall_chunk", 32'(disp_chunk), 32'd0);
        check("full_stall_valid", 32'(disp_valid), 32'd1);
        disp_ready = 1'b1;
        step();
        check("full_c1", 32'(disp_chunk), 32'd1);
        step();
        step();
        check("full_c3_last", 32'(disp_last), 32'd1);
        set_alloc(OP_VADD, 9'h000, 5'd30, 5'd24, 5'd21, 1'b0, 4'b1111, 4'b0000);
        check("full_alloc_ready_blocked", 32'(alloc_ready), 32'd0);
        step();
        check("full_freed_rs_full", 32'(rs_full), 32'd0);
        check("full_freed_free", 32'(free_count), 32'd1);
        check("full_freed_alloc_ready", 32'(alloc_ready), 32'd1);
        step();
        alloc_valid = 1'b0;
        check("full_refill_rs_full", 32'(rs_full), 32'd1);
        check("full_refill_free", 32'(free_count), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd24; wb_v_chunk = 2'd0;
        step();
        wb_v_valid = 1'b0;
        check("full_refill_valid", 32'(disp_valid), 32'd1);
        check("full_refill_idx", 32'(disp_idx), 32'd3);
        check("full_refill_dest", 32'(disp_dest), 32'd30);

        // Reset mid-operation discards everything
        do_reset();
        check("midrst_free", 32'(free_count), 32'd4);
        check("midrst_valid", 32'(disp_valid), 32'd0);
        check("midrst_rs_full", 32'(rs_full), 32'd0);

        // Alloc in the final-chunk cycle with room left: count unchanged
        set_alloc(OP_VADD, 9'h000, 5'd1, 5'd1, 5'd2, 1'b0, 4'b0000, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("swap_free_a", 32'(free_count), 32'd3);
        step();
        step();
        step();
        check("swap_last", 32'(disp_last), 32'd1);
        set_alloc(OP_VADD, 9'h000, 5'd2, 5'd25, 5'd2, 1'b0, 4'b1111, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("swap_free_b", 32'(free_count), 32'd3);
        check("swap_valid", 32'(disp_valid), 32'd0);
        wb_v_valid = 1'b1; wb_v_reg = 5'd25; wb_v_chunk = 2'd0;
        step();
        wb_v_valid = 1'b0;
        check("swap_idx", 32'(disp_idx), 32'd1);
        check("swap_dest", 32'(disp_dest), 32'd2);

        // Same-cycle wakeup bypass into the allocating entry
        do_reset();
        disp_ready = 1'b0;
        set_alloc(OP_VADD, 9'h000, 5'd13, 5'd14, 5'd12, 1'b0, 4'b0000, 4'b0001);
        wb_v_valid = 1'b1; wb_v_reg = 5'd12; wb_v_chunk = 2'd0;
        step();
        alloc_valid = 1'b0;
        wb_v_valid = 1'b0;
        check("bypass_v_valid", 32'(disp_valid), 32'd1);
        check("bypass_v_chunk", 32'(disp_chunk), 32'd0);
        do_reset();
        set_alloc(OP_VADD, 9'h000, 5'd13, 5'd15, 5'd12, 1'b1, 4'b1111, 4'b0000);
        wb_s_valid = 1'b1; wb_s_reg = 5'd15;
        step();
        alloc_valid = 1'b0;
        wb_s_valid = 1'b0;
        check("bypass_s_valid", 32'(disp_valid), 32'd1);

        // Priority: A(idx0), B(idx1); free A; C(idx0); B and C woken together
        do_reset();
        disp_ready = 1'b1;
        set_alloc(OP_VADD, 9'h000, 5'd1, 5'd26, 5'd2, 1'b1, 4'b1111, 4'b0000);
        step();
        set_alloc(OP_VADD, 9'h000, 5'd2, 5'd27, 5'd2, 1'b1, 4'b1111, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("prio_blocked", 32'(disp_valid), 32'd0);
        wb_s_valid = 1'b1; wb_s_reg = 5'd26;
        step();
        wb_s_valid = 1'b0;
        check("prio_a_idx", 32'(disp_idx), 32'd0);
        check("prio_a_dest", 32'(disp_dest), 32'd1);
        for (int c = 0; c < 4; c++) step();
        check("prio_a_freed", 32'(free_count), 32'd3);
        set_alloc(OP_VADD, 9'h000, 5'd3, 5'd27, 5'd2, 1'b1, 4'b1111, 4'b0000);
        step();
        alloc_valid = 1'b0;
        check("prio_c_alloc_free", 32'(free_count), 32'd2);
        check("prio_c_blocked", 32'(disp_valid), 32'd0);
        wb_s_valid = 1'b1; wb_s_reg = 5'd27;
        step();
        wb_s_valid = 1'b0;
`ifdef RS_V_AGE_PRIO_EN
        first_dest  = 2;
        second_dest = 3;
`else
        first_dest  = 3;
        second_dest = 2;
`endif
        check("prio_first_dest", 32'(disp_dest), 32'(first_dest));
        for (int c = 0; c < 4; c++) step();
        check("prio_second_dest", 32'(disp_dest), 32'(second_dest));
        for (int c = 0; c < 4; c++) step();
        check("prio_done_free", 32'(free_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_v_issue.md
Name: rs_v_issue

Overview:
- Vector reservation-station issue unit: the consumer side of the decode stage's vector RS writes.
- Holds decoded vector load, store and add/sub entries and tracks per-chunk source readiness from writeback broadcasts.
- Issues each instruction to the vector execution pipe as 4 chunks of 8 elements, then frees the entry.
- Sits between decode and the vector execute/LSU stage.

Parameters:
- RS_SIZE, 4, number of vector RS entries (2..16).
- IDX_W, 2, entry index width; equals clog2(RS_SIZE).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  1  decode presents an entry
- alloc_ready  out  1  a free entry exists (!rs_full)
- alloc_opcode  in  7  instr[6:0]
- alloc_func  in  9  {instr[31:26], instr[14:12]}
- alloc_dest  in  5  vd
- alloc_src1  in  5  rs1 or vs1
- alloc_src2  in  5  vs2
- alloc_src1_scalar  in  1  src1 is a scalar register (load, store, vsub)
- alloc_src1_busy  in  4  per-chunk busy mask of src1; bit j = chunk j not ready
- alloc_src2_busy  in  4  per-chunk busy mask of src2
- wb_v_valid  in  1  vector chunk writeback broadcast
- wb_v_reg  in  5  vector register written
- wb_v_chunk  in  2  chunk index written
- wb_s_valid  in  1  scalar writeback broadcast
- wb_s_reg  in  5  scalar register written
- disp_valid  out  1  a chunk is ready to issue
- disp_ready  in  1  execute accepts
- disp_opcode  out  7
- disp_func  out  9
- disp_dest  out  5
- disp_src1  out  5
- disp_src2  out  5
- disp_chunk  out  2  chunk being issued
- disp_last  out  1  disp_chunk == 3
- disp_idx  out  IDX_W  RS entry issuing
- rs_full  out  1  all entries valid
- free_count  out  IDX_W+1  number of free entries

Behaviour:
- Reset:
  - All entries invalid; next_chunk = 0.
  - disp_valid = 0, disp_* fields = 0.
  - rs_full = 0, free_count = RS_SIZE, alloc_ready = 1.
  - Reset mid-operation discards all entries; the in-flight dispatch is not accepted.
- Allocation:
  - Fires when alloc_valid & alloc_ready.
  - Writes the lowest-index invalid entry; sets valid, next_chunk = 0.
  - alloc_ready, rs_full and free_count derive from registered valid bits only. An entry freed in cycle N is allocatable from cycle N+1.
- Wakeup:
  - wb_v_valid clears bit wb_v_chunk of src1_busy in every valid entry where src1 == wb_v_reg and src1_scalar == 0.
  - The same broadcast clears that bit of src2_busy where src2 == wb_v_reg.
  - wb_s_valid clears all 4 bits of src1_busy where src1 == wb_s_reg and src1_scalar == 1.
  - Wakeup is bypassed into an entry allocated the same cycle: captured masks equal alloc masks with that cycle's wakeup applied.
  - Both broadcasts may occur in the same cycle; both apply.
- Ready rule:
  - Entry e is ready when valid and bit next_chunk is 0 in both src1_busy and src2_busy.
  - Stores check src2 per chunk and src1 only as a whole.
  - Masks from decode are 1111/1110/1100/1000/0000, but any pattern is legal.
- Select:
  - Combinational from registered state. disp_valid = any entry ready.
  - The chosen entry drives disp_* and disp_chunk = next_chunk.
  - Default priority: lowest index.
- Dispatch:
  - Fires when disp_valid & disp_ready.
  - On fire, next_chunk increments.
  - If disp_last, the entry clears valid and next_chunk returns to 0.
  - A wakeup in the fire cycle affects selection from the next cycle.
  - disp_ready low holds state; the selection may change while stalled if a higher-priority entry becomes ready.
- Latency:
  - Entry allocated ready in cycle N: earliest chunk-0 dispatch in cycle N+1.
  - Full instruction with continuous disp_ready: 4 consecutive cycles.
- Simultaneous alloc and final-chunk dispatch: both take effect; free_count unchanged next cycle.
- Opcodes other than 0000111, 0100111 and 1010111 are stored and issued unchanged; no checking is performed.

Optional Feature:
- Macro RS_V_AGE_PRIO_EN.
- Defined:
  - Each entry holds an age rank of IDX_W bits.
  - On allocation the new entry takes rank = number of valid entries.
  - On free, all entries with larger rank decrement.
  - Select picks the ready entry with the smallest rank (oldest first).
- Undefined: lowest-index priority; no age state.

Test Plan:
- Reset, then alloc vadd with masks 0000/0000 in cycle 1, disp_ready = 1 -> disp_chunk 0,1,2,3 in cycles 2-5; disp_last in cycle 5; free_count back to 4 in cycle 6.
- Alloc vsub with src1_scalar = 1, src1_busy = 1111, src2 = 0000 -> no dispatch; wb_s_valid with matching reg -> chunk 0 dispatches the next cycle.
- Alloc store with src2_busy = 1110; wb_v chunk1 at cycle 5, chunk2 at cycle 8 -> chunk0 issues, chunk1 after cycle 5, chunk2 after cycle 8, chunk3 never until its wakeup.
- Fill 4 entries -> rs_full = 1, alloc_ready = 0; final-chunk dispatch and alloc_valid in the same cycle -> alloc is not accepted that cycle, is accepted the next, and lands in the freed index.
- Allocate with a matching wb_v_valid in the same cycle -> the captured mask has that chunk bit cleared.
- With RS_V_AGE_PRIO_EN: alloc entries A (idx0) and B (idx1); free A; alloc C (idx0); all ready -> order B then C. Without the macro -> C then B.
